uart_rx_err_fifo: RTL

//  Parametrised RX FIFO placed between the UART RX deserialiser and the register/bus interface.
//  - Each entry stores the received data plus per-character parity, framing and break status.
//  - Head entry is presented first-word-fall-through (FWFT).
//  - Provides a programmable fill-level interrupt, a 16550-style character-timeout interrupt,
//    a sticky, software-clearable overflow flag and a count of error-carrying entries.

---
 rtl/uart_rx_err_fifo_if.sv | 45 ++++
 rtl/uart_rx_err_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_err_fifo_if.sv
// Bus between the UART RX FIFO and the side that writes characters, pops them and configures it.
// The master drives characters, pops and configuration; the FIFO (slave) returns the head entry and status.
interface uart_rx_err_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_W  = 10
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_perr;
    logic                  wr_ferr;
    logic                  wr_brk;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_perr;
    logic                  rd_ferr;
    logic                  rd_brk;
    logic                  fifo_clear;
    logic [AW:0]           threshold;
    logic [TIMEOUT_W-1:0]  timeout_cycles;
    logic                  ovf_clr;
    logic                  empty;
    logic                  full;
    logic [AW:0]           level;
    logic                  thresh_irq;
    logic                  timeout_irq;
    logic                  overflow;
    logic                  err_pending;

    modport master (
        output wr_data, wr_perr, wr_ferr, wr_brk, wr_en, rd_en,
        output fifo_clear, threshold, timeout_cycles, ovf_clr,
        input  rd_data, rd_perr, rd_ferr, rd_brk,
        input  empty, full, level, thresh_irq, timeout_irq, overflow, err_pending
    );

    modport slave (
        input  wr_data, wr_perr, wr_ferr, wr_brk, wr_en, rd_en,
        input  fifo_clear, threshold, timeout_cycles, ovf_clr,
        output rd_data, rd_perr, rd_ferr, rd_brk,
        output empty, full, level, thresh_irq, timeout_irq, overflow, err_pending
    );
endinterface

// File: rtl/uart_rx_err_fifo.sv
// UART RX FIFO storing each character with its parity/framing/break status, FWFT head,
// fill-level and character-timeout interrupts, sticky overflow and an error-entry count.
module uart_rx_err_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_W  = 10
) (
    input logic                clk,
    input logic                rst_n,
    uart_rx_err_fifo_if.slave  bus
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              EW       = DATA_WIDTH + 3;
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [TIMEOUT_W-1:0] TO_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] TO_ONES = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] TO_ONE  = TIMEOUT_W'(1);

    // An entry carries an error when any of its three status flags is set.
    function automatic logic any_err(input logic perr, input logic ferr, input logic brk);
        return perr | ferr | brk;
    endfunction

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic [AW:0]          r_err_cnt;
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 r_ovf;
    logic                 r_to_irq;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_mem_we;
    logic                 w_ovf_set;
    logic                 w_wr_err;
    logic                 w_rd_err;
    logic                 w_to_hold;
    logic [EW-1:0]        w_head;
    logic [EW-1:0]        w_wr_entry;

    // Accept decisions; a read of a full FIFO frees the slot the concurrent write lands in.
    always_comb begin
        w_empty    = (r_level == LVL_ZERO);
        w_full     = (r_level == LVL_FULL);
        w_rd_acc   = bus.rd_en & ~w_empty;
        w_wr_acc   = bus.wr_en & (~w_full | bus.rd_en);
        w_mem_we   = w_wr_acc & ~bus.fifo_clear;
        w_ovf_set  = bus.wr_en & w_full & ~bus.rd_en;
        w_head     = r_mem[r_rd_ptr];
        w_wr_entry = {bus.wr_brk, bus.wr_ferr, bus.wr_perr, bus.wr_data};
        w_wr_err   = any_err(bus.wr_perr, bus.wr_ferr, bus.wr_brk);
        w_rd_err   = any_err(w_head[DATA_WIDTH], w_head[DATA_WIDTH+1], w_head[DATA_WIDTH+2]);
        w_to_hold  = w_empty | w_wr_acc | w_rd_acc;
    end

    // Entry storage; left unreset since validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers and fill level; flush discards any access in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= LVL_ZERO;
        end else if (bus.fifo_clear) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= LVL_ZERO;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Count of stored entries that carry any error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= LVL_ZERO;
        end else if (bus.fifo_clear) begin
            r_err_cnt <= LVL_ZERO;
        end else begin
            case ({w_wr_acc & w_wr_err, w_rd_acc & w_rd_err})
                2'b10:   r_err_cnt <= r_err_cnt + LVL_ONE;
                2'b01:   r_err_cnt <= r_err_cnt - LVL_ONE;
                default: r_err_cnt <= r_err_cnt;
            endcase
        end
    end

    // Sticky overflow; a new drop in the same cycle as the clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (bus.fifo_clear) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // Character timeout: idle cycles with data waiting, saturating; irq raised on match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= TO_ZERO;
            r_to_irq <= 1'b0;
        end else if (bus.fifo_clear) begin
            r_to_cnt <= TO_ZERO;
            r_to_irq <= 1'b0;
        end else if (w_to_hold) begin
            r_to_cnt <= TO_ZERO;
            r_to_irq <= 1'b0;
        end else begin
            if (r_to_cnt != TO_ONES) begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end
            if ((bus.timeout_cycles != TO_ZERO) && (r_to_cnt == bus.timeout_cycles)) begin
                r_to_irq <= 1'b1;
            end
        end
    end

    // Head entry falls through while data is present; status decoded from the registers.
    always_comb begin
        bus.rd_data = {DATA_WIDTH{1'b0}};
        bus.rd_perr = 1'b0;
        bus.rd_ferr = 1'b0;
        bus.rd_brk  = 1'b0;
        if (!w_empty) begin
            bus.rd_data = w_head[DATA_WIDTH-1:0];
            bus.rd_perr = w_head[DATA_WIDTH];
            bus.rd_ferr = w_head[DATA_WIDTH+1];
            bus.rd_brk  = w_head[DATA_WIDTH+2];
        end else begin
            bus.rd_data = {DATA_WIDTH{1'b0}};
        end
        bus.empty       = w_empty;
        bus.full        = w_full;
        bus.level       = r_level;
        bus.thresh_irq  = (bus.threshold != LVL_ZERO) && (r_level >= bus.threshold);
        bus.timeout_irq = r_to_irq;
        bus.overflow    = r_ovf;
        bus.err_pending = (r_err_cnt != LVL_ZERO);
    end
endmodule
